// File: rtl/inst_fetch_if.sv
// Bus bundle between the instruction fetch unit, the PC controller, the
// instruction memory and decode. The fetch unit uses the master modport;
// the surrounding environment uses the slave modport.
// Optional member align_fault exists only when IFETCH_ALIGN_CHECK_EN is defined.
interface inst_fetch_if;
    logic [31:0] pc;
    logic        redirect;
    logic        stall;
    logic        pc_enable;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        is_nop;
    logic [31:0] fetch_count;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    modport master (
        input  pc, redirect, stall, mem_ack, mem_rdata,
        output pc_enable, mem_req, mem_addr, inst, inst_pc, inst_valid,
               is_nop, fetch_count
`ifdef IFETCH_ALIGN_CHECK_EN
        , output align_fault
`endif
    );

    modport slave (
        output pc, redirect, stall, mem_ack, mem_rdata,
        input  pc_enable, mem_req, mem_addr, inst, inst_pc, inst_valid,
               is_nop, fetch_count
`ifdef IFETCH_ALIGN_CHECK_EN
        , input align_fault
`endif
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch responder: fetches the word at the current PC over a
// req/ack memory handshake, presents it to decode with its PC, and grants
// pc_enable only when an instruction is accepted downstream. Decode stalls
// are absorbed by a one-entry hold buffer; redirects squash into bubbles.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned PC detection).
module inst_fetch #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        pc_enable_c;
    logic        mem_req_c;
    logic        deliver_c;
    logic        pc_aligned;
    logic [31:0] fetch_addr;

    assign fetch_addr = {bus.pc[31:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
    logic align_fault_q, align_fault_d;
    assign pc_aligned = (bus.pc[1:0] == 2'b00);

    // Misaligned PC seen while requesting latches a sticky fault flag.
    always_comb begin
        align_fault_d = align_fault_q;
        if (state_q == REQ && !pc_aligned) begin
            align_fault_d = 1'b1;
        end
    end

    // Fault flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= align_fault_d;
        end
    end

    assign bus.align_fault = align_fault_q;
`else
    // Low PC bits are ignored: the containing word is fetched.
    assign pc_aligned = 1'b1;
`endif

    // Next state, handshake outputs and output-register loads.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        pc_enable_c  = 1'b0;
        mem_req_c    = 1'b0;
        deliver_c    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (bus.redirect || !bus.stall) begin
                    inst_d       = NOP_WORD;
                    inst_valid_d = 1'b0;
                end
            end
            REQ: begin
                mem_req_c = pc_aligned;
                if (pc_aligned && bus.mem_ack && (!bus.stall || bus.redirect)) begin
                    // Accepted downstream (or squashed): the PC may advance.
                    pc_enable_c = 1'b1;
                    if (bus.redirect) begin
                        inst_d       = NOP_WORD;
                        inst_valid_d = 1'b0;
                    end else begin
                        inst_d       = bus.mem_rdata;
                        inst_pc_d    = fetch_addr;
                        inst_valid_d = 1'b1;
                        deliver_c    = 1'b1;
                    end
                end else if (pc_aligned && bus.mem_ack) begin
                    // Decode is stalled: park the word until it can be taken.
                    hold_inst_d = bus.mem_rdata;
                    hold_pc_d   = fetch_addr;
                    state_d     = HOLD;
                end else if (bus.redirect || !bus.stall) begin
                    inst_d       = NOP_WORD;
                    inst_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    pc_enable_c  = 1'b1;
                    inst_d       = NOP_WORD;
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end else if (!bus.stall) begin
                    pc_enable_c  = 1'b1;
                    inst_d       = hold_inst_q;
                    inst_pc_d    = hold_pc_q;
                    inst_valid_d = 1'b1;
                    deliver_c    = 1'b1;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        fetch_count_d = fetch_count_q + {31'd0, deliver_c};
    end

    // State, output register, hold buffer and delivery counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            inst_q        <= NOP_WORD;
            inst_pc_q     <= 32'd0;
            inst_valid_q  <= 1'b0;
            hold_inst_q   <= NOP_WORD;
            hold_pc_q     <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.pc_enable   = pc_enable_c;
    assign bus.mem_req     = mem_req_c;
    assign bus.mem_addr    = fetch_addr;
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.is_nop      = ~inst_valid_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch. The bench plays PC controller and wait-state
// memory; a transaction-level reference model (pending word, expected
// output register, delivery count) predicts every observable value.
module tb_inst_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    inst_fetch_if ifc();
    inst_fetch #(.NOP_WORD(NOP)) dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] pc;
    bit          m_idle;
    bit          m_pend;
    logic [31:0] m_pend_pc, m_pend_data;
    logic [31:0] e_inst, e_inst_pc, e_cnt;
    bit          e_valid;
    bit          e_fault;
    int          wcnt;
    logic [31:0] special_addr = 32'hFFFF_FFF0;
    logic [31:0] special_data = 32'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == special_addr) return special_data;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, answer memory, check, clock, update model.
    task automatic cycle(input bit rst, input bit st, input bit rd, input int waits,
                         input bit fack, input logic [31:0] tgt);
        bit exp_req, ack, eff, exp_pe;
        logic [31:0] addr;
        reset        = rst;
        ifc.stall    = st;
        ifc.redirect = rd;
        ifc.pc       = pc;
        ifc.mem_ack  = 1'b0;
        ifc.mem_rdata = $urandom;
        addr = {pc[31:2], 2'b00};
`ifdef IFETCH_ALIGN_CHECK_EN
        exp_req = !m_idle && !m_pend && (pc[1:0] == 2'b00);
`else
        exp_req = !m_idle && !m_pend;
`endif
        #1;
        ack = fack;
        if (ifc.mem_req && wcnt >= waits) ack = 1'b1;
        ifc.mem_ack = ack;
        if (ack) ifc.mem_rdata = memfn(ifc.mem_addr);
        @(negedge clk);
        eff    = ack && exp_req;
        exp_pe = (eff || m_pend) && (!st || rd);
        chk("mem_req", {31'd0, ifc.mem_req}, {31'd0, exp_req});
        chk("mem_addr", ifc.mem_addr, addr);
        if (!rst) chk("pc_enable", {31'd0, ifc.pc_enable}, {31'd0, exp_pe});
        @(posedge clk);
        #1;
        if (rst) begin
            m_idle = 1; m_pend = 0; e_inst = NOP; e_inst_pc = 0; e_valid = 0;
            e_cnt = 0; e_fault = 0; wcnt = 0; pc = tgt;
        end else begin
            if (!m_idle && !m_pend && pc[1:0] != 2'b00) e_fault = 1;
            if (rd) begin
                e_inst = NOP; e_valid = 0; m_pend = 0;
            end else if (st) begin
                if (eff) begin m_pend = 1; m_pend_pc = addr; m_pend_data = memfn(addr); end
            end else if (eff) begin
                e_inst = memfn(addr); e_inst_pc = addr; e_valid = 1; e_cnt++;
            end else if (m_pend) begin
                e_inst = m_pend_data; e_inst_pc = m_pend_pc; e_valid = 1; e_cnt++; m_pend = 0;
            end else begin
                e_inst = NOP; e_valid = 0;
            end
            m_idle = 0;
            if (exp_pe) pc = rd ? tgt : pc + 32'd4;
            wcnt = (exp_req && !eff) ? wcnt + 1 : 0;
        end
        chk("inst", ifc.inst, e_inst);
        chk("inst_valid", {31'd0, ifc.inst_valid}, {31'd0, e_valid});
        chk("is_nop", {31'd0, ifc.is_nop}, {31'd0, !e_valid});
        chk("fetch_count", ifc.fetch_count, e_cnt);
        if (e_valid) chk("inst_pc", ifc.inst_pc, e_inst_pc);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("align_fault", {31'd0, ifc.align_fault}, {31'd0, e_fault});
`endif
        if (ifc.inst_valid)
            $display("deliver pc=%h inst=%h count=%0d", ifc.inst_pc, ifc.inst, ifc.fetch_count);
    endtask

    initial begin
        pc = 0; m_idle = 1; m_pend = 0; e_inst = NOP; e_inst_pc = 0; e_valid = 0;
        e_cnt = 0; e_fault = 0; wcnt = 0; m_pend_pc = 0; m_pend_data = 0;
        ifc.pc = 0; ifc.stall = 0; ifc.redirect = 0; ifc.mem_ack = 0; ifc.mem_rdata = 0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1, 0, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 0, 32'h0);
        chk("rst_inst", ifc.inst, NOP);
        chk("rst_inst_pc", ifc.inst_pc, 32'h0);
        chk("rst_valid", {31'd0, ifc.inst_valid}, 32'd0);
        chk("rst_is_nop", {31'd0, ifc.is_nop}, 32'd1);
        chk("rst_count", ifc.fetch_count, 32'd0);
        chk("rst_mem_req", {31'd0, ifc.mem_req}, 32'd0);

        // Zero-wait memory: IDLE cycle, then one instruction per cycle
        cycle(0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 32'h0);
        chk("zw_inst_pc", ifc.inst_pc, 32'h8);
        chk("zw_count", ifc.fetch_count, 32'd3);

        // 2-wait memory at pc=0x40
        cycle(1, 0, 0, 0, 0, 32'h40);
        cycle(0, 0, 0, 2, 0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 2, 0, 32'h0);
        chk("w2_inst_pc", ifc.inst_pc, 32'h40);
        chk("w2_valid", {31'd0, ifc.inst_valid}, 32'd1);

        // Stall at ack for three cycles, then release
        special_addr = 32'h44;
        special_data = 32'h2002_0005;
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 32'h0);
        chk("stall_held_pc", ifc.inst_pc, 32'h40);
        cycle(0, 0, 0, 0, 0, 32'h0);
        chk("stall_inst", ifc.inst, 32'h2002_0005);
        chk("stall_inst_pc", ifc.inst_pc, 32'h44);

        // Redirect together with ack
        cycle(0, 0, 1, 0, 0, 32'h100);
        chk("redir_inst", ifc.inst, NOP);
        chk("redir_is_nop", {31'd0, ifc.is_nop}, 32'd1);
        chk("redir_count", ifc.fetch_count, 32'd2);
        cycle(0, 0, 0, 0, 0, 32'h0);
        chk("redir_target", ifc.inst_pc, 32'h100);

        // Reset while awaiting ack, then a stray ack
        cycle(0, 0, 0, 3, 0, 32'h0);
        cycle(1, 0, 0, 5, 0, 32'h200);
        chk("rstreq_mem_req", {31'd0, ifc.mem_req}, 32'd0);
        chk("rstreq_valid", {31'd0, ifc.inst_valid}, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'h0);
        chk("stray_ack_count", ifc.fetch_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 10), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 99) < 5), {22'd0, 8'($urandom), 2'b00});
        end

        // Misaligned PC
        cycle(1, 0, 0, 0, 0, 32'h42);
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 32'h0);
        chk("align_fault_set", {31'd0, ifc.align_fault}, 32'd1);
        chk("align_no_req", {31'd0, ifc.mem_req}, 32'd0);
`else
        cycle(0, 0, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 0, 0, 32'h0);
        chk("misalign_inst_pc", ifc.inst_pc, 32'h40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
